// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, FSM state encoding, default operand width and op helpers.
package ex_muldiv_unit_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// Single iteration of the iterative multiply/divide datapath.
// Multiply: radix-2 shift-add on {hi,lo}, multiplier consumed from lo[0].
// Divide (only when MULDIV_DIV_EN is defined): restoring shift-subtract,
// hi holds the partial remainder and lo shifts dividend bits out / quotient in.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
`else
  logic           unused_div;
  assign unused_div = div_i;
`endif

  // Compute the next accumulator pair for whichever operation is running
  always_comb begin
    mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    hi_o    = mul_sum[WIDTH:1];
    lo_o    = {mul_sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {hi_i, lo_i[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_i};
    if (div_i) begin
      if (!div_diff[WIDTH]) begin
        hi_o = div_diff[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = div_shift[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operations run on magnitudes for WIDTH cycles, then one FIXUP cycle
// restores signs and writes HI/LO. Divide support is built only when
// the MULDIV_DIV_EN macro is defined; otherwise DIV/DIVU report err.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data_in,
  input  logic [WIDTH-1:0] rt_data_in,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  muldiv_state_e      state_q;
  muldiv_op_e         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opb_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_q, rem_neg_q;
  logic               busy_q, done_q, err_q;

  muldiv_op_e         op_d;
  logic               rs_neg_d, rt_neg_d;
  logic [WIDTH-1:0]   rs_abs_d, rt_abs_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d, rem_d;
  logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;
  logic [WIDTH-1:0]   step_hi_d, step_lo_d;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (op_is_div(op_q)),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .b_i   (opb_q),
    .hi_o  (step_hi_d),
    .lo_o  (step_lo_d)
  );

  // Operand magnitudes/signs for launch and sign-corrected results for FIXUP
  always_comb begin
    op_d     = muldiv_op_e'(op);
    rs_neg_d = op_is_signed(op_d) & rs_data_in[WIDTH-1];
    rt_neg_d = op_is_signed(op_d) & rt_data_in[WIDTH-1];
    rs_abs_d = rs_neg_d ? -rs_data_in : rs_data_in;
    rt_abs_d = rt_neg_d ? -rt_data_in : rt_data_in;
    prod_d   = {acc_hi_q, acc_lo_q};
    if (neg_q) prod_d = -prod_d;
    quo_d    = neg_q ? -acc_lo_q : acc_lo_q;
    rem_d    = rem_neg_q ? -acc_hi_q : acc_hi_q;
    if (op_is_div(op_q)) begin
      fix_hi_d = rem_d;
      fix_lo_d = quo_d;
    end else begin
      fix_hi_d = prod_d[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_d[WIDTH-1:0];
    end
  end

  // Control FSM with registered busy/done/err, working datapath and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!busy_q) begin
        if (mthi) hi_q <= rs_data_in;
        if (mtlo) lo_q <= rs_data_in;
      end
      if (flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            state_q <= ST_IDLE;
            if (start) begin
              op_q <= op_d;
              if (op_is_div(op_d)) begin
`ifdef MULDIV_DIV_EN
                if (rt_data_in == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                end else begin
                  state_q   <= ST_RUN;
                  busy_q    <= 1'b1;
                  cnt_q     <= CNT_INIT;
                  acc_hi_q  <= '0;
                  acc_lo_q  <= rs_abs_d;
                  opb_q     <= rt_abs_d;
                  neg_q     <= rs_neg_d ^ rt_neg_d;
                  rem_neg_q <= rs_neg_d;
                end
`else
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
`endif
              end else begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                cnt_q     <= CNT_INIT;
                acc_hi_q  <= '0;
                acc_lo_q  <= rt_abs_d;
                opb_q     <= rs_abs_d;
                neg_q     <= rs_neg_d ^ rt_neg_d;
                rem_neg_q <= 1'b0;
              end
            end
          end
          ST_RUN: begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= ST_FIXUP;
          end
          ST_FIXUP: begin
            hi_q    <= fix_hi_d;
            lo_q    <= fix_lo_d;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH = 32).
// Divide result tests are built when MULDIV_DIV_EN is defined; otherwise
// the bench checks that DIV/DIVU report err with HI/LO unchanged.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data_in;
  logic [W-1:0] rt_data_in;
  logic         flush;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .rs_data_in (rs_data_in),
    .rt_data_in (rt_data_in),
    .flush      (flush),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Launch one op from a negedge and wait (bounded) for done; cycles counts
  // edges from the sampling edge, so the sampling edge itself is cycle 1
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int cycles);
    @(negedge clk);
    op = o; rs_data_in = a; rt_data_in = b; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Count done pulses over a fixed window
  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
  endtask

  // Preload HI and LO through the direct-write path
  task automatic load_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    @(negedge clk); mthi = 1'b1; rs_data_in = h;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; rs_data_in = l;
    @(negedge clk); mtlo = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data_in = '0; rt_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hi_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mult();
    int cyc;
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 34", cyc); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", lo_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL mult_err: got %b expected 0", err); end
    run_op(OP_MULT, 32'h00000007, 32'hFFFFFFFB, cyc);
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFF_FFFFFFDD) begin errors++; $display("[TB] FAIL mult_7x-5: got %h expected ffffffffffffffdd", {hi_out, lo_out}); end
    run_op(OP_MULT, 32'h80000000, 32'h80000000, cyc);
    checks++; if ({hi_out, lo_out} !== 64'h40000000_00000000) begin errors++; $display("[TB] FAIL mult_minxmin: got %h expected 4000000000000000", {hi_out, lo_out}); end
  endtask

  task automatic test_multu();
    int cyc;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 34", cyc); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFFFFFE_00000001) begin errors++; $display("[TB] FAIL multu_max: got %h expected fffffffe00000001", {hi_out, lo_out}); end
  endtask

  task automatic test_div_zero();
    int cyc;
    load_hilo(32'h11111111, 32'h22222222);
    run_op(OP_DIV, 32'h00000005, 32'h00000000, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL divzero_latency: got %0d expected 1", cyc); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL divzero_err: got %b expected 1", err); end
    checks++; if (hi_out !== 32'h11111111) begin errors++; $display("[TB] FAIL divzero_hi: got %h expected 11111111", hi_out); end
    checks++; if (lo_out !== 32'h22222222) begin errors++; $display("[TB] FAIL divzero_lo: got %h expected 22222222", lo_out); end
    @(posedge clk); #1;
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("[TB] FAIL divzero_pulse: got %b expected 00", {done, err}); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int cyc;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 34", cyc); end
    checks++; if (lo_out !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_-7/2_quo: got %h expected fffffffd", lo_out); end
    checks++; if (hi_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_-7/2_rem: got %h expected ffffffff", hi_out); end
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, cyc);
    checks++; if ({hi_out, lo_out} !== {32'h00000001, 32'hFFFFFFFD}) begin errors++; $display("[TB] FAIL div_7/-2: got %h expected 00000001fffffffd", {hi_out, lo_out}); end
    run_op(OP_DIVU, 32'd100, 32'd7, cyc);
    checks++; if (lo_out !== 32'd14) begin errors++; $display("[TB] FAIL divu_quo: got %0d expected 14", lo_out); end
    checks++; if (hi_out !== 32'd2) begin errors++; $display("[TB] FAIL divu_rem: got %0d expected 2", hi_out); end
  endtask

  task automatic test_div_overflow();
    int cyc;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (lo_out !== 32'h80000000) begin errors++; $display("[TB] FAIL divovf_quo: got %h expected 80000000", lo_out); end
    checks++; if (hi_out !== 32'h00000000) begin errors++; $display("[TB] FAIL divovf_rem: got %h expected 00000000", hi_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL divovf_err: got %b expected 0", err); end
  endtask
`else
  task automatic test_div_disabled();
    int cyc;
    load_hilo(32'h33333333, 32'h44444444);
    run_op(OP_DIVU, 32'd9, 32'd3, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL divoff_latency: got %0d expected 1", cyc); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL divoff_err: got %b expected 1", err); end
    checks++; if ({hi_out, lo_out} !== 64'h33333333_44444444) begin errors++; $display("[TB] FAIL divoff_hilo: got %h expected 3333333344444444", {hi_out, lo_out}); end
  endtask
`endif

  task automatic test_mthi_mtlo();
    int cyc;
    @(negedge clk);
    mthi = 1'b1; start = 1'b1; op = OP_MULTU; rs_data_in = 32'd5; rt_data_in = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; cyc = 1;
    checks++; if (hi_out !== 32'd5) begin errors++; $display("[TB] FAIL mthi_with_start: got %h expected 00000005", hi_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mthi_launch_busy: got %b expected 1", busy); end
    @(negedge clk); mtlo = 1'b1; rs_data_in = 32'hDEADBEEF;
    @(posedge clk); #1; mtlo = 1'b0; cyc++;
    checks++; if (lo_out === 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mtlo_while_busy: got %h expected not deadbeef", lo_out); end
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL mt_op_latency: got %0d expected 34", cyc); end
    checks++; if ({hi_out, lo_out} !== 64'd20) begin errors++; $display("[TB] FAIL mt_op_result: got %h expected 0000000000000014", {hi_out, lo_out}); end
  endtask

  task automatic test_flush();
    int nd;
    load_hilo(32'hAAAA5555, 32'h5555AAAA);
    @(negedge clk);
    op = OP_MULTU; rs_data_in = 32'h1234; rt_data_in = 32'h10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL flush_nodone: got %0d expected 0", nd); end
    checks++; if ({hi_out, lo_out} !== 64'hAAAA5555_5555AAAA) begin errors++; $display("[TB] FAIL flush_hilo: got %h expected aaaa55555555aaaa", {hi_out, lo_out}); end
  endtask

  task automatic test_rst_mid_run();
    int nd;
    int cyc;
    @(negedge clk);
    op = OP_MULTU; rs_data_in = 32'h77; rt_data_in = 32'h99; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 000", {busy, done, err}); end
    checks++; if ({hi_out, lo_out} !== 64'h0) begin errors++; $display("[TB] FAIL rst_hilo: got %h expected 0", {hi_out, lo_out}); end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL rst_nodone: got %0d expected 0", nd); end
    run_op(OP_MULTU, 32'd6, 32'd7, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL rst_after_latency: got %0d expected 34", cyc); end
    checks++; if ({hi_out, lo_out} !== 64'd42) begin errors++; $display("[TB] FAIL rst_after_result: got %h expected 000000000000002a", {hi_out, lo_out}); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    int nd;
    @(negedge clk);
    op = OP_MULT; rs_data_in = 32'd3; rt_data_in = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); op = OP_MULT; rs_data_in = 32'd100; rt_data_in = 32'd100; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc++;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 34", cyc); end
    checks++; if ({hi_out, lo_out} !== 64'd9) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected 0000000000000009", {hi_out, lo_out}); end
    count_dones(40, nd);
    checks++; if (nd !== 0) begin errors++; $display("[TB] FAIL busy_start_queued: got %0d expected 0", nd); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(OP_MULTU, 32'd2, 32'd3, cyc);
    checks++; if (lo_out !== 32'd6) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 6", lo_out); end
    run_op(OP_MULTU, 32'd10, 32'd10, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", cyc); end
    checks++; if (lo_out !== 32'd100) begin errors++; $display("[TB] FAIL b2b_second: got %0d expected 100", lo_out); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div_zero();
`ifdef MULDIV_DIV_EN
    test_div();
    test_div_overflow();
`else
    test_div_disabled();
`endif
    test_mthi_mtlo();
    test_flush();
    test_rst_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
